sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO. It succeeds the fixed 32-bit FIFO and serves as the general buffering primitive between streaming blocks in one clock domain.
- Generalises data width, depth, almost-full/almost-empty thresholds and read mode (standard or first-word-fall-through).
- Adds an occupancy count and sticky overflow/underflow error flags.

---
 rtl/sync_fifo_param_if.sv | 34 +++
 rtl/sync_fifo_param.sv | 116 +++++++++++
 tb/tb_sync_fifo_param.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_param_if.sv
// Handshake bundle between a streaming producer/consumer and sync_fifo_param.
// The FIFO side uses the slave modport; whoever drives writes/reads uses master.
interface sync_fifo_param_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              valid;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic              almost_empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;
    logic              clr_err;

    modport master (
        output wr_en, wr_data, rd_en, clr_err,
        input  rd_data, valid, empty, full, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, clr_err,
        output rd_data, valid, empty, full, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags, sticky
// overflow/underflow errors and a choice of registered or fall-through read.
module sync_fifo_param #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter bit FWFT      = 1'b0
) (
    input logic             clk,
    input logic             rst,
    sync_fifo_param_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              empty, full;
    logic              wr_acc, rd_acc;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    // A new error in the same cycle as clr_err must win, so the set is applied last.
    always_comb begin
        wr_acc      = bus.wr_en & ~full;
        rd_acc      = bus.rd_en & ~empty;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
        if (bus.clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (bus.wr_en & full) begin
            overflow_d = 1'b1;
        end
        if (bus.rd_en & empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset; only accepted writes touch it.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    assign bus.empty        = empty;
    assign bus.full         = full;
    assign bus.almost_full  = (count_q >= CNT_W'(AF_THRESH));
    assign bus.almost_empty = (count_q <= CNT_W'(AE_THRESH));
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

    if (FWFT) begin : g_fwft
        assign bus.rd_data = mem_q[rd_ptr_q];
        assign bus.valid   = ~empty;
    end else begin : g_std
        logic [DATA_W-1:0] rd_data_q, rd_data_d;
        logic              valid_q, valid_d;

        // rd_data keeps its last word when no read is accepted; valid pulses per pop.
        always_comb begin
            rd_data_d = rd_data_q;
            valid_d   = rd_acc;
            if (rd_acc) begin
                rd_data_d = mem_q[rd_ptr_q];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_data_q <= '0;
                valid_q   <= 1'b0;
            end else begin
                rd_data_q <= rd_data_d;
                valid_q   <= valid_d;
            end
        end

        assign bus.rd_data = rd_data_q;
        assign bus.valid   = valid_q;
    end
endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench: a standard-read and a fall-through FIFO share one stimulus
// stream and are compared against a queue-based model plus fixed vector tables.
module tb_sync_fifo_param;
    localparam int DW    = 16;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus0 ();
    sync_fifo_param_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus1 ();

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1'b0))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1'b1))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DW-1:0] ref_q[$];
    logic          ref_ov    = 1'b0;
    logic          ref_un    = 1'b0;
    logic          ref_valid = 1'b0;
    logic [DW-1:0] ref_rd    = '0;

    typedef struct {
        logic          r, w;
        logic [DW-1:0] wd;
        logic          rd, clr;
        int            cnt;
        logic          emp, ful, ov, un, vld;
        logic [DW-1:0] rdd;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // The model only knows an ordered list of stored words and the acceptance rules.
    task automatic modelEdge(input logic r, input logic w, input logic [DW-1:0] wd,
                             input logic rd, input logic clr);
        bit was_full, was_empty;
        if (r) begin
            ref_q.delete();
            ref_ov    = 1'b0;
            ref_un    = 1'b0;
            ref_valid = 1'b0;
            ref_rd    = '0;
        end else begin
            was_full  = (ref_q.size() == DEPTH);
            was_empty = (ref_q.size() == 0);
            if (rd && !was_empty) begin
                ref_rd    = ref_q.pop_front();
                ref_valid = 1'b1;
            end else begin
                ref_valid = 1'b0;
            end
            if (w && !was_full) ref_q.push_back(wd);
            if (w && was_full) ref_ov = 1'b1;
            else if (clr) ref_ov = 1'b0;
            if (rd && was_empty) ref_un = 1'b1;
            else if (clr) ref_un = 1'b0;
        end
    endtask

    task automatic checkOutput();
        int n;
        n = ref_q.size();
        chk("count_std",  32'(bus0.count), 32'(n));
        chk("count_fwft", 32'(bus1.count), 32'(n));
        chk("empty_std",  32'(bus0.empty), 32'(n == 0));
        chk("empty_fwft", 32'(bus1.empty), 32'(n == 0));
        chk("full_std",   32'(bus0.full),  32'(n == DEPTH));
        chk("full_fwft",  32'(bus1.full),  32'(n == DEPTH));
        chk("afull_std",  32'(bus0.almost_full),  32'(n >= 14));
        chk("aempty_std", 32'(bus0.almost_empty), 32'(n <= 2));
        chk("afull_fwft", 32'(bus1.almost_full),  32'(n >= 14));
        chk("aempty_fwft",32'(bus1.almost_empty), 32'(n <= 2));
        chk("ovf_std",    32'(bus0.overflow),  32'(ref_ov));
        chk("unf_std",    32'(bus0.underflow), 32'(ref_un));
        chk("ovf_fwft",   32'(bus1.overflow),  32'(ref_ov));
        chk("unf_fwft",   32'(bus1.underflow), 32'(ref_un));
        chk("valid_std",  32'(bus0.valid),   32'(ref_valid));
        chk("rdata_std",  32'(bus0.rd_data), 32'(ref_rd));
        chk("valid_fwft", 32'(bus1.valid),   32'(n != 0));
        if (n != 0) chk("rdata_fwft", 32'(bus1.rd_data), 32'(ref_q[0]));
    endtask

    // Inputs change 1ns after an edge, are sampled at the next edge, outputs checked 1ns later.
    task automatic applyStimulus(input logic r, input logic w, input logic [DW-1:0] wd,
                                 input logic rd, input logic clr);
        rst          = r;
        bus0.wr_en   = w;  bus1.wr_en   = w;
        bus0.wr_data = wd; bus1.wr_data = wd;
        bus0.rd_en   = rd; bus1.rd_en   = rd;
        bus0.clr_err = clr; bus1.clr_err = clr;
        @(posedge clk);
        modelEdge(r, w, wd, rd, clr);
        #1;
        checkOutput();
    endtask

    initial begin
        vec_t vecs[12];
        int   writes;
        bit   w, r;

        vecs[0]  = '{1, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0000};
        vecs[1]  = '{1, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0000};
        vecs[2]  = '{0, 0, 16'h0000, 1, 0, 0, 1, 0, 0, 1, 0, 16'h0000};
        vecs[3]  = '{0, 0, 16'h0000, 0, 1, 0, 1, 0, 0, 0, 0, 16'h0000};
        vecs[4]  = '{0, 1, 16'h0011, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0000};
        vecs[5]  = '{0, 1, 16'h0022, 0, 0, 2, 0, 0, 0, 0, 0, 16'h0000};
        vecs[6]  = '{0, 0, 16'h0000, 1, 0, 1, 0, 0, 0, 0, 1, 16'h0011};
        vecs[7]  = '{0, 1, 16'h0033, 1, 0, 1, 0, 0, 0, 0, 1, 16'h0022};
        vecs[8]  = '{0, 0, 16'h0000, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0022};
        vecs[9]  = '{0, 0, 16'h0000, 1, 0, 0, 1, 0, 0, 0, 1, 16'h0033};
        vecs[10] = '{0, 1, 16'h0044, 1, 0, 1, 0, 0, 0, 1, 0, 16'h0033};
        vecs[11] = '{1, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0000};

        rst = 1'b1;
        bus0.wr_en = 1'b0; bus0.rd_en = 1'b0; bus0.clr_err = 1'b0; bus0.wr_data = '0;
        bus1.wr_en = 1'b0; bus1.rd_en = 1'b0; bus1.clr_err = 1'b0; bus1.wr_data = '0;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].r, vecs[i].w, vecs[i].wd, vecs[i].rd, vecs[i].clr);
            chk($sformatf("tbl%0d_count", i), 32'(bus0.count),     32'(vecs[i].cnt));
            chk($sformatf("tbl%0d_empty", i), 32'(bus0.empty),     32'(vecs[i].emp));
            chk($sformatf("tbl%0d_full", i),  32'(bus0.full),      32'(vecs[i].ful));
            chk($sformatf("tbl%0d_ovf", i),   32'(bus0.overflow),  32'(vecs[i].ov));
            chk($sformatf("tbl%0d_unf", i),   32'(bus0.underflow), 32'(vecs[i].un));
            chk($sformatf("tbl%0d_valid", i), 32'(bus0.valid),     32'(vecs[i].vld));
            chk($sformatf("tbl%0d_rdata", i), 32'(bus0.rd_data),   32'(vecs[i].rdd));
        end

        // Fill to full, watching almost_full appear at 14, then drain in order.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 1, DW'(i), 0, 0);
            if (i == 12) chk("fill_afull_13", 32'(bus0.almost_full), 32'd0);
            if (i == 13) chk("fill_afull_14", 32'(bus0.almost_full), 32'd1);
        end
        chk("fill_count", 32'(bus0.count), 32'd16);
        chk("fill_full",  32'(bus0.full),  32'd1);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 0, '0, 1, 0);
            chk("drain_data",  32'(bus0.rd_data), 32'(i));
            chk("drain_valid", 32'(bus0.valid),   32'd1);
        end
        chk("drain_empty", 32'(bus0.empty), 32'd1);
        applyStimulus(0, 0, '0, 0, 0);
        chk("drain_valid_off", 32'(bus0.valid), 32'd0);

        // Overflow, clear, clear-versus-set, and read+write while full.
        for (int i = 0; i < 16; i++) applyStimulus(0, 1, DW'(16'h0100 + i), 0, 0);
        applyStimulus(0, 1, 16'hDEAD, 0, 0);
        chk("ovf_set",   32'(bus0.overflow), 32'd1);
        chk("ovf_count", 32'(bus0.count),    32'd16);
        applyStimulus(0, 0, '0, 0, 1);
        chk("ovf_clear", 32'(bus0.overflow), 32'd0);
        applyStimulus(0, 1, 16'hDEAD, 0, 1);
        chk("ovf_set_wins", 32'(bus0.overflow), 32'd1);
        applyStimulus(0, 0, '0, 0, 1);
        applyStimulus(0, 1, 16'hBEEF, 1, 0);
        chk("full_both_count", 32'(bus0.count),    32'd15);
        chk("full_both_ovf",   32'(bus0.overflow), 32'd1);
        chk("full_both_data",  32'(bus0.rd_data),  32'h0100);
        for (int i = 1; i < 16; i++) begin
            applyStimulus(0, 0, '0, 1, 0);
            chk("ovf_drain_data", 32'(bus0.rd_data), 32'h0100 + 32'(i));
        end

        // Simultaneous read and write at count 5 keeps count and order.
        applyStimulus(1, 0, '0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, DW'(16'h0200 + i), 0, 0);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 1, DW'(16'h0300 + k), 1, 0);
            chk("sim5_count", 32'(bus0.count), 32'd5);
            chk("sim5_data",  32'(bus0.rd_data), (k < 5) ? 32'h0200 + 32'(k) : 32'h0300 + 32'(k - 5));
        end
        applyStimulus(1, 0, '0, 0, 0);
        applyStimulus(0, 1, 16'h0077, 1, 0);
        chk("empty_both_count", 32'(bus0.count),     32'd1);
        chk("empty_both_unf",   32'(bus0.underflow), 32'd1);

        // Wrap-around: 40 random-data writes with occupancy held between 3 and 6.
        applyStimulus(1, 0, '0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, DW'($urandom), 0, 0);
        writes = 3;
        while (writes < 40) begin
            w = 1'($urandom);
            r = 1'($urandom);
            if (ref_q.size() <= 3) w = 1'b1;
            if (ref_q.size() >= 6) r = 1'b1;
            applyStimulus(0, w, DW'($urandom), r, 0);
            if (w) writes++;
        end

        // Unconstrained random traffic including errors, clears and resets.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(49) == 0), 1'($urandom), DW'($urandom),
                          1'($urandom), 1'($urandom_range(7) == 0));
        end

        // Fall-through: word visible without rd_en, pop empties, reset clears valid.
        applyStimulus(1, 0, '0, 0, 0);
        applyStimulus(0, 1, 16'h00A5, 0, 0);
        chk("fwft_valid", 32'(bus1.valid),   32'd1);
        chk("fwft_data",  32'(bus1.rd_data), 32'h00A5);
        applyStimulus(0, 0, '0, 1, 0);
        chk("fwft_pop_empty", 32'(bus1.empty), 32'd1);
        chk("fwft_pop_valid", 32'(bus1.valid), 32'd0);
        for (int i = 0; i < 7; i++) applyStimulus(0, 1, DW'(16'h0500 + i), 0, 0);
        chk("fwft_count7", 32'(bus1.count), 32'd7);
        applyStimulus(1, 0, '0, 0, 0);
        chk("fwft_rst_count", 32'(bus1.count), 32'd0);
        chk("fwft_rst_valid", 32'(bus1.valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
